uart_tx_param: RTL and testbench

//  Parametrised UART transmit engine with integrated TX FIFO, for the dual-core UART.
//  - Serialises 5..8-bit characters with optional parity, 1/1.5/2 stop bits and break.
//  - Adds over the current transmitter: configurable FIFO depth and oversampling,
//    CTS flow control, a frame-done pulse, and a line-idle status.
//  - Sits between the bus register file (lcr, THR writes) and the stx pad.

---
 rtl/uart_tx_param.sv | 158 +++++++++++++++
 tb/tb_uart_tx_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmit engine with an integrated TX FIFO.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   enable           baud tick, OVS ticks per bit
//   lcr              [1:0] bits-5, [2] SB, [3] PE, [4] EP, [5] SP, [6] BC
//   tf_push, dat_i   FIFO write strobe and character
//   tx_reset         synchronous FIFO flush (frame in flight completes)
//   lsr_mask         clears tf_overrun
//   cts_n            clear-to-send, active low, sampled only in IDLE when CTS_EN=1
//   stx_pad_o        serial line
//   tstate           FSM state
//   tf_count         FIFO occupancy
//   tf_overrun       sticky push-while-full flag
//   tx_done          1-clk pulse at the end of each stop bit
//   tx_idle          FIFO empty and FSM idle
module uart_tx_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5,
  parameter int OVS        = 16,
  parameter int CTS_EN     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       lcr,
  input  logic             tf_push,
  input  logic [7:0]       dat_i,
  input  logic             tx_reset,
  input  logic             lsr_mask,
  input  logic             cts_n,
  output logic             stx_pad_o,
  output logic [2:0]       tstate,
  output logic [CNT_W-1:0] tf_count,
  output logic             tf_overrun,
  output logic             tx_done,
  output logic             tx_idle
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(2 * OVS);
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, POP = 3'd5} state_e;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
  logic             full, empty, push_ok, pop_ok, tf_pop;
  state_e           st_q, st_d;
  logic [TW-1:0]    tick_q, tick_d, tick_last;
  logic [2:0]       bit_q, bit_d, last_bit;
  logic [7:0]       sh_q, sh_d, head, mask;
  logic             par_q, par_d, par_bit, tick_end;
  logic             stx_q, stx_d, done_q, done_d, idle_q;
  logic             lcr_unused;
  assign lcr_unused = lcr[7];
  assign full    = cnt_q == CNT_W'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign push_ok = tf_push & ~full;
  assign pop_ok  = tf_pop & ~empty;
  always_comb begin
    wr_d  = tx_reset ? '0 : wr_q + AW'(push_ok);
    rd_d  = tx_reset ? '0 : rd_q + AW'(pop_ok);
    cnt_d = tx_reset ? '0 : cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    // a push that overflows beats a simultaneous lsr_mask clear
    ovr_d = (tf_push & full & ~tx_reset) ? 1'b1 : lsr_mask ? 1'b0 : ovr_q;
  end
  always_ff @(posedge clk) begin
    if (push_ok && !tx_reset) mem_q[wr_q] <= dat_i;
  end
  assign head     = mem_q[rd_q];
  assign mask     = ~(8'he0 << lcr[1:0]);
  assign last_bit = {1'b1, lcr[1:0]};
  // {EP,SP}: 00 odd, 01 one, 10 even, 11 zero
  assign par_bit  = lcr[5] ? ~lcr[4] : (^(head & mask)) ^ ~lcr[4];
  // only the stop bit may stretch beyond one bit period
  assign tick_last = (st_q != STOP || !lcr[2]) ? TW'(OVS - 1) :
                     (lcr[1:0] == 2'd0) ? TW'(3 * OVS / 2 - 1) : TW'(2 * OVS - 1);
  assign tick_end  = tick_q == tick_last;
  always_comb begin
    st_d   = st_q;
    tick_d = tick_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    tf_pop = 1'b0;
    done_d = 1'b0;
    if (enable) begin
      tick_d = tick_end ? '0 : tick_q + TW'(1);
      case (st_q)
        IDLE: begin
          tick_d = '0;
          if (!empty && (CTS_EN == 0 || !cts_n)) st_d = POP;
        end
        POP: begin
          tick_d = '0;
          if (empty) st_d = IDLE;
          else begin
            tf_pop = 1'b1;
            sh_d   = head;
            par_d  = par_bit;
            bit_d  = last_bit;
            st_d   = START;
          end
        end
        START: if (tick_end) st_d = DATA;
        DATA: if (tick_end) begin
          if (bit_q == 3'd0) st_d = lcr[3] ? PARITY : STOP;
          else begin
            bit_d = bit_q - 3'd1;
            sh_d  = sh_q >> 1;
          end
        end
        PARITY: if (tick_end) st_d = STOP;
        STOP: if (tick_end) begin
          st_d   = IDLE;
          done_d = 1'b1;
        end
        default: st_d = IDLE;
      endcase
    end
  end
  // line level is registered from the next state so it changes with tstate
  assign stx_d = (st_d == START) ? 1'b0 : (st_d == DATA) ? sh_d[0] : (st_d == PARITY) ? par_d : 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      st_q   <= IDLE;
      tick_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      stx_q  <= 1'b1;
      done_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      st_q   <= st_d;
      tick_q <= tick_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      stx_q  <= stx_d;
      done_q <= done_d;
      idle_q <= (cnt_d == '0) && (st_d == IDLE);
    end
  end
  // break overrides the line without disturbing the FSM
  assign stx_pad_o  = stx_q & ~lcr[6];
  assign tstate     = st_q;
  assign tf_count   = cnt_q;
  assign tf_overrun = ovr_q;
  assign tx_done    = done_q;
  assign tx_idle    = idle_q;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized scoreboard bench with a serial-line receiver model.
module tb_uart_tx_param;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int OVS   = 16;
  logic clk = 0, rst_n = 0, enable = 0, tf_push = 0, tx_reset = 0, lsr_mask = 0, cts_n = 0;
  logic [7:0] lcr = 8'h03, dat_i = 8'h00;
  logic stx_pad_o, tf_overrun, tx_done, tx_idle;
  logic [2:0] tstate;
  logic [CW-1:0] tf_count;
  uart_tx_param #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .OVS(OVS), .CTS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .lcr(lcr), .tf_push(tf_push), .dat_i(dat_i),
    .tx_reset(tx_reset), .lsr_mask(lsr_mask), .cts_n(cts_n), .stx_pad_o(stx_pad_o),
    .tstate(tstate), .tf_count(tf_count), .tf_overrun(tf_overrun), .tx_done(tx_done), .tx_idle(tx_idle));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 enable = ~enable;
  end
  typedef struct { logic [7:0] d; int nb; bit pe; bit pb; int stop; } frame_t;
  frame_t expq[$];
  int tests = 0, fails = 0, frames = 0;
  bit mon_en = 0, burst = 0, busy = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic frame_t model(logic [7:0] d, logic [7:0] l);
    frame_t f;
    int ones;
    f.nb   = 5 + int'(l[1:0]);
    f.d    = d & 8'((1 << f.nb) - 1);
    ones   = $countones(f.d);
    f.pe   = l[3];
    f.pb   = l[5] ? !l[4] : (l[4] ? (ones % 2 == 1) : (ones % 2 == 0));
    f.stop = !l[2] ? OVS : (f.nb == 5 ? OVS * 3 / 2 : 2 * OVS);
    return f;
  endfunction
  task automatic push(logic [7:0] d, bit expect_frame);
    @(posedge clk);
    #1;
    if (expect_frame) expq.push_back(model(d, lcr));
    tf_push = 1;
    dat_i = d;
    @(posedge clk);
    #1 tf_push = 0;
  endtask
  task automatic drain(string nm);
    int i;
    for (i = 0; i < 20000 && !(tx_idle && expq.size() == 0 && !busy); i++) @(negedge clk);
    chk(nm, 32'(i < 20000), 1);
    repeat (4) @(negedge clk);
  endtask
  task automatic wait_state(logic [2:0] s, string nm);
    int i;
    for (i = 0; i < 4000 && tstate !== s; i++) @(negedge clk);
    chk(nm, 32'(tstate), 32'(s));
  endtask
  task automatic wait_done(string nm);
    int i;
    for (i = 0; i < 4000 && tx_done !== 1'b1; i++) @(negedge clk);
    chk(nm, 32'(tx_done), 1);
  endtask
  // receiver: counts baud ticks from the start edge and samples mid-bit
  initial begin
    logic e, prev_stx;
    int n, base, since_done;
    frame_t cur;
    logic [7:0] rx;
    prev_stx = 1;
    since_done = -1;
    n = 0;
    rx = 0;
    forever begin
      @(posedge clk);
      e = enable;
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        busy = 0;
        since_done = -1;
      end else if (!busy) begin
        if (e && since_done >= 0) since_done++;
        if (tx_done) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: tx_done=1 with no frame in progress at %0t", $time);
        end
        if (prev_stx && !stx_pad_o) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_frame: start bit with empty scoreboard at %0t", $time);
          end else begin
            cur = expq.pop_front();
            busy = 1;
            n = 0;
            rx = 0;
            if (burst && since_done >= 0) chk("idle_gap_ticks", 32'(since_done), 2);
          end
        end
      end else begin
        if (e) n++;
        base = OVS * (1 + cur.nb);
        if (e) begin
          if (n == OVS / 2) chk("start_bit", 32'(stx_pad_o), 0);
          for (int i = 0; i < cur.nb; i++) if (n == OVS * (1 + i) + OVS / 2) rx[i] = stx_pad_o;
          if (cur.pe && n == base + OVS / 2) chk("parity_bit", 32'(stx_pad_o), 32'(cur.pb));
        end
        if (cur.pe) base += OVS;
        if (e && n == base + OVS / 2) chk("stop_level", 32'(stx_pad_o), 1);
        if (tx_done) begin
          chk("done_tick", 32'(n), 32'(base + cur.stop));
          chk("rx_data", 32'(rx), 32'(cur.d));
          busy = 0;
          frames++;
          since_done = burst ? 0 : -1;
        end else if (n > base + cur.stop) begin
          tests++;
          fails++;
          $display("FAIL done_missing: no tx_done by tick %0d, expected tick %0d", n, base + cur.stop);
          busy = 0;
        end
      end
      prev_stx = stx_pad_o;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] dir_lcr [5];
    logic [7:0] dir_dat [5];
    int f0, r;
    dir_lcr = '{8'h03, 8'h1B, 8'h0B, 8'h04, 8'h07};
    dir_dat = '{8'h55, 8'h07, 8'h07, 8'h13, 8'hA6};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stx", 32'(stx_pad_o), 1);
    chk("rst_tstate", 32'(tstate), 0);
    chk("rst_count", 32'(tf_count), 0);
    chk("rst_overrun", 32'(tf_overrun), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_idle", 32'(tx_idle), 1);
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;
    for (int k = 0; k < 5; k++) begin
      lcr = dir_lcr[k];
      push(dir_dat[k], 1);
      drain("directed_drain");
    end
    for (int k = 0; k < 6; k++) begin
      r = $urandom;
      lcr = 8'(r & 63);
      for (int j = 0; j < 5; j++) begin
        for (int i = 0; i < 1000 && tf_count >= CW'(DEPTH - 1); i++) @(negedge clk);
        r = $urandom;
        push(8'(r), 1);
        repeat ($urandom_range(0, 60)) @(posedge clk);
      end
      drain("random_drain");
    end
    lcr = 8'h03;
    cts_n = 1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      r = $urandom;
      push(8'(r), k < DEPTH);
    end
    repeat (40) @(posedge clk);
    #1;
    chk("full_count", 32'(tf_count), DEPTH);
    chk("full_overrun", 32'(tf_overrun), 1);
    chk("cts_line_idle", 32'(stx_pad_o), 1);
    chk("cts_tstate", 32'(tstate), 0);
    lsr_mask = 1;
    @(posedge clk);
    #1 lsr_mask = 0;
    chk("overrun_cleared", 32'(tf_overrun), 0);
    f0 = frames;
    burst = 1;
    cts_n = 0;
    drain("burst_drain");
    chk("burst_frames", 32'(frames - f0), DEPTH);
    burst = 0;
    lcr = 8'h0B;
    for (int k = 0; k < 3; k++) push(8'(k * 37 + 5), 1);
    wait_state(3'd4, "reach_stop");
    @(posedge clk);
    #1 tx_reset = 1;
    expq.delete();
    @(posedge clk);
    #1 tx_reset = 0;
    chk("flush_count", 32'(tf_count), 0);
    wait_done("flush_done");
    chk("flush_idle", 32'(tx_idle), 1);
    repeat (600) @(negedge clk);
    chk("flush_stays_idle", 32'(tstate), 0);
    mon_en = 0;
    lcr = 8'h43;
    push(8'hA5, 0);
    wait_state(3'd2, "bc_fsm_runs");
    chk("bc_line_low", 32'(stx_pad_o), 0);
    wait_done("bc_done");
    lcr = 8'h03;
    repeat (4) @(negedge clk);
    chk("bc_release", 32'(stx_pad_o), 1);
    push(8'hC3, 0);
    push(8'h3C, 0);
    wait_state(3'd2, "reach_data");
    repeat (10) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_stx", 32'(stx_pad_o), 1);
    chk("arst_tstate", 32'(tstate), 0);
    chk("arst_count", 32'(tf_count), 0);
    chk("arst_idle", 32'(tx_idle), 1);
    @(negedge clk);
    rst_n = 1;
    repeat (600) @(negedge clk);
    chk("arst_stays_idle", 32'(tstate), 0);
    mon_en = 1;
    repeat (4) @(negedge clk);
    r = $urandom;
    push(8'(r), 1);
    drain("post_reset_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
